// File: rtl/vector_writeback_assembler_pkg.sv
// -----------------------------------------------------------------------------
// vector_writeback_assembler_pkg
// Shared constants, FSM state type and lane-slice helper for the vector
// writeback assembler and its gather lane buffer.
// -----------------------------------------------------------------------------
package vector_writeback_assembler_pkg;

  localparam int NUM_LANES      = 16;
  localparam int LANE_WIDTH     = 32;
  localparam int REG_IDX_WIDTH  = 7;
  localparam int LANE_IDX_WIDTH = $clog2(NUM_LANES);
  localparam int VEC_WIDTH      = NUM_LANES * LANE_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Bit offset of lane n inside a full-width vector.
  function automatic int unsigned lane_offset(input int unsigned lane);
    return lane * LANE_WIDTH;
  endfunction

endpackage

// File: rtl/vector_writeback_assembler_if.sv
// -----------------------------------------------------------------------------
// vector_writeback_assembler_if
// Bundles the gather control, lane delivery, ALU writeback and register file
// write port of the vector writeback assembler.
//   master : the environment (execute/memory stages + register file observer)
//   slave  : the assembler itself
// -----------------------------------------------------------------------------
interface vector_writeback_assembler_if;
  import vector_writeback_assembler_pkg::*;

  // gather control
  logic                      start_i;
  logic [REG_IDX_WIDTH-1:0]  dest_reg_i;
  logic [NUM_LANES-1:0]      lane_mask_i;
  logic                      busy_o;
  // lane delivery
  logic                      lane_valid_i;
  logic [LANE_IDX_WIDTH-1:0] lane_index_i;
  logic [LANE_WIDTH-1:0]     lane_data_i;
  logic                      lane_ready_o;
  // ALU writeback
  logic                      full_valid_i;
  logic [REG_IDX_WIDTH-1:0]  full_reg_i;
  logic [VEC_WIDTH-1:0]      full_value_i;
  logic [NUM_LANES-1:0]      full_mask_i;
  // register file write port
  logic                      write_en_o;
  logic [REG_IDX_WIDTH-1:0]  write_reg_o;
  logic [VEC_WIDTH-1:0]      write_value_o;
  logic [NUM_LANES-1:0]      write_mask_o;
  logic                      gather_done_o;
  logic                      lane_err_o;

  modport master (
    output start_i, dest_reg_i, lane_mask_i,
    output lane_valid_i, lane_index_i, lane_data_i,
    output full_valid_i, full_reg_i, full_value_i, full_mask_i,
    input  busy_o, lane_ready_o,
    input  write_en_o, write_reg_o, write_value_o, write_mask_o,
    input  gather_done_o, lane_err_o
  );

  modport slave (
    input  start_i, dest_reg_i, lane_mask_i,
    input  lane_valid_i, lane_index_i, lane_data_i,
    input  full_valid_i, full_reg_i, full_value_i, full_mask_i,
    output busy_o, lane_ready_o,
    output write_en_o, write_reg_o, write_value_o, write_mask_o,
    output gather_done_o, lane_err_o
  );

endinterface

// File: rtl/vector_writeback_assembler_gather_lane_buffer.sv
// -----------------------------------------------------------------------------
// gather_lane_buffer
// Staging storage for one gather: per-lane data slots, received bits and the
// latched lane mask.
//   clk, reset      : clock, synchronous active-high reset
//   clear_i         : latch mask_i, zero all slots and received bits
//   mask_i          : lane mask to latch on clear
//   wr_en_i         : a lane result is accepted this cycle
//   wr_idx_i        : lane number of the accepted result
//   wr_data_i       : lane result
//   mask_o          : latched mask
//   in_mask_o       : wr_idx_i is a lane of the latched mask
//   all_received_o  : received bits, including this cycle's write, equal mask
//   data_o          : staged vector, lanes outside the mask forced to zero
// -----------------------------------------------------------------------------
module gather_lane_buffer
  import vector_writeback_assembler_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic [NUM_LANES-1:0]      mask_i,
  input  logic                      wr_en_i,
  input  logic [LANE_IDX_WIDTH-1:0] wr_idx_i,
  input  logic [LANE_WIDTH-1:0]     wr_data_i,
  output logic [NUM_LANES-1:0]      mask_o,
  output logic                      in_mask_o,
  output logic                      all_received_o,
  output logic [VEC_WIDTH-1:0]      data_o
);

  logic [NUM_LANES-1:0] mask_q;
  logic [NUM_LANES-1:0] received_q;
  logic [NUM_LANES-1:0] hit;

  // Only lanes inside the mask may touch storage; stray lanes are dropped.
  assign hit            = wr_en_i ? ((NUM_LANES'(1) << wr_idx_i) & mask_q) : '0;
  assign in_mask_o      = mask_q[wr_idx_i];
  assign all_received_o = ((received_q | hit) == mask_q);
  assign mask_o         = mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= '0;
      received_q <= '0;
    end else if (clear_i) begin
      mask_q     <= mask_i;
      received_q <= '0;
    end else begin
      received_q <= received_q | hit;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [LANE_WIDTH-1:0] slot_q;

      // Duplicates simply overwrite the slot.
      always_ff @(posedge clk) begin
        if (reset || clear_i) begin
          slot_q <= '0;
        end else if (hit[gi]) begin
          slot_q <= wr_data_i;
        end
      end

      assign data_o[lane_offset(gi) +: LANE_WIDTH] = mask_q[gi] ? slot_q : '0;
    end
  endgenerate

endmodule

// File: rtl/vector_writeback_assembler.sv
// -----------------------------------------------------------------------------
// vector_writeback_assembler
// Producer side of the vector register file's masked write port. Collects
// gather-load lane results into a staging buffer and issues one masked write
// once every requested lane has arrived; full-width ALU writebacks share the
// port and always win it.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : slave modport of vector_writeback_assembler_if carrying gather
//           control, lane delivery, ALU writeback and the registered write
//           port (write_*, gather_done_o, lane_err_o, busy_o, lane_ready_o)
// -----------------------------------------------------------------------------
module vector_writeback_assembler
  import vector_writeback_assembler_pkg::*;
(
  input logic                         clk,
  input logic                         reset,
  vector_writeback_assembler_if.slave bus
);

  state_t                   state_q, state_d;
  logic [REG_IDX_WIDTH-1:0] dest_reg_q, dest_reg_d;

  logic                     write_en_q, write_en_d;
  logic [REG_IDX_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [VEC_WIDTH-1:0]     write_value_q, write_value_d;
  logic [NUM_LANES-1:0]     write_mask_q, write_mask_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     busy_q, ready_q;

  logic                     buf_clear;
  logic                     lane_accept;
  logic                     lane_in_mask;
  logic                     all_received;
  logic                     gather_fire;
  logic [NUM_LANES-1:0]     buf_mask;
  logic [VEC_WIDTH-1:0]     buf_data;

  // ready_q mirrors state_q == COLLECT, so this is the lane handshake.
  assign lane_accept = (state_q == COLLECT) && bus.lane_valid_i;

  gather_lane_buffer u_buffer (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (buf_clear),
    .mask_i         (bus.lane_mask_i),
    .wr_en_i        (lane_accept),
    .wr_idx_i       (bus.lane_index_i),
    .wr_data_i      (bus.lane_data_i),
    .mask_o         (buf_mask),
    .in_mask_o      (lane_in_mask),
    .all_received_o (all_received),
    .data_o         (buf_data)
  );

  always_comb begin
    state_d     = state_q;
    dest_reg_d  = dest_reg_q;
    buf_clear   = 1'b0;
    gather_fire = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.lane_mask_i != '0) begin
            buf_clear  = 1'b1;
            dest_reg_d = bus.dest_reg_i;
            state_d    = COLLECT;
          end else begin
            // Empty gather completes immediately without touching the port.
            done_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (lane_accept) begin
          if (!lane_in_mask) begin
            err_d = 1'b1;
          end else if (all_received) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // The gather waits here for as long as the ALU keeps the port busy.
        if (!bus.full_valid_i) begin
          gather_fire = 1'b1;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Write port mux; data fields hold when nothing is written.
    write_en_d    = 1'b0;
    write_reg_d   = write_reg_q;
    write_value_d = write_value_q;
    write_mask_d  = write_mask_q;
    if (bus.full_valid_i) begin
      write_en_d    = 1'b1;
      write_reg_d   = bus.full_reg_i;
      write_value_d = bus.full_value_i;
      write_mask_d  = bus.full_mask_i;
    end else if (gather_fire) begin
      write_en_d    = 1'b1;
      write_reg_d   = dest_reg_q;
      write_value_d = buf_data;
      write_mask_d  = buf_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      dest_reg_q    <= '0;
      write_en_q    <= 1'b0;
      write_reg_q   <= '0;
      write_value_q <= '0;
      write_mask_q  <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_reg_q    <= dest_reg_d;
      write_en_q    <= write_en_d;
      write_reg_q   <= write_reg_d;
      write_value_q <= write_value_d;
      write_mask_q  <= write_mask_d;
      done_q        <= done_d;
      err_q         <= err_d;
      // Registered from the next state so they line up with state_q.
      busy_q        <= (state_d != IDLE);
      ready_q       <= (state_d == COLLECT);
    end
  end

  assign bus.write_en_o    = write_en_q;
  assign bus.write_reg_o   = write_reg_q;
  assign bus.write_value_o = write_value_q;
  assign bus.write_mask_o  = write_mask_q;
  assign bus.gather_done_o = done_q;
  assign bus.lane_err_o    = err_q;
  assign bus.busy_o        = busy_q;
  assign bus.lane_ready_o  = ready_q;

endmodule

// File: tb/tb_vector_writeback_assembler.sv
// -----------------------------------------------------------------------------
// tb_vector_writeback_assembler
// Self-checking bench: ALU vector table, directed gather sequences, then
// random traffic compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_vector_writeback_assembler;
  import vector_writeback_assembler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vector_writeback_assembler_if vif();

  vector_writeback_assembler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         fv;
    logic [6:0]   r;
    logic [15:0]  m;
    logic [511:0] v;
    logic         exp_en;
    logic [6:0]   exp_r;
    logic [15:0]  exp_m;
    logic [511:0] exp_v;
  } alu_vec_t;

  alu_vec_t tbl [5];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.start_i      = 1'b0;
    vif.dest_reg_i   = '0;
    vif.lane_mask_i  = '0;
    vif.lane_valid_i = 1'b0;
    vif.lane_index_i = '0;
    vif.lane_data_i  = '0;
    vif.full_valid_i = 1'b0;
    vif.full_reg_i   = '0;
    vif.full_value_i = '0;
    vif.full_mask_i  = '0;
  endtask

  task automatic start_gather(input logic [6:0] r, input logic [15:0] m);
    vif.start_i     = 1'b1;
    vif.dest_reg_i  = r;
    vif.lane_mask_i = m;
    step();
    vif.start_i     = 1'b0;
  endtask

  task automatic send_lane(input logic [3:0] idx, input logic [31:0] d);
    vif.lane_valid_i = 1'b1;
    vif.lane_index_i = idx;
    vif.lane_data_i  = d;
    step();
    vif.lane_valid_i = 1'b0;
  endtask

  task automatic check_write(input string name, input logic [6:0] r, input logic [15:0] m,
                             input logic [511:0] v, input logic done);
    check({name, ".en"},   512'(vif.write_en_o), 512'(1'b1));
    check({name, ".reg"},  512'(vif.write_reg_o), 512'(r));
    check({name, ".mask"}, 512'(vif.write_mask_o), 512'(m));
    check({name, ".value"}, vif.write_value_o, v);
    check({name, ".done"}, 512'(vif.gather_done_o), 512'(done));
  endtask

  // Reference model state (transaction view: active gather + lanes missing)
  bit           m_active;
  logic [15:0]  m_gmask, m_remaining;
  logic [6:0]   m_greg;
  logic [31:0]  m_data [16];
  logic [6:0]   m_last_reg;
  logic [15:0]  m_last_mask;
  logic [511:0] m_last_value;

  initial begin
    logic [511:0] v;
    logic [31:0]  w;

    idle_inputs();
    reset = 1'b1;
    step();
    check("rst.en",    512'(vif.write_en_o), 512'(0));
    check("rst.reg",   512'(vif.write_reg_o), 512'(0));
    check("rst.value", vif.write_value_o, 512'(0));
    check("rst.mask",  512'(vif.write_mask_o), 512'(0));
    check("rst.done",  512'(vif.gather_done_o), 512'(0));
    check("rst.err",   512'(vif.lane_err_o), 512'(0));
    check("rst.busy",  512'(vif.busy_o), 512'(0));
    check("rst.ready", 512'(vif.lane_ready_o), 512'(0));
    reset = 1'b0;
    step();

    // ---------------- ALU vector table ----------------
    tbl[0] = '{1'b1, 7'h25, 16'hFFFF, {64{8'hA5}}, 1'b1, 7'h25, 16'hFFFF, {64{8'hA5}}};
    tbl[1] = '{1'b1, 7'h7F, 16'h00F0, {16{32'h0000_0001}}, 1'b1, 7'h7F, 16'h00F0, {16{32'h0000_0001}}};
    tbl[2] = '{1'b0, 7'h11, 16'h1234, {16{32'hFFFF_0000}}, 1'b0, 7'h7F, 16'h00F0, {16{32'h0000_0001}}};
    tbl[3] = '{1'b1, 7'h00, 16'h0000, 512'd0, 1'b1, 7'h00, 16'h0000, 512'd0};
    tbl[4] = '{1'b1, 7'h3A, 16'h8001, {32'hDEAD_BEEF, {14{32'h0}}, 32'h1234_5678},
               1'b1, 7'h3A, 16'h8001, {32'hDEAD_BEEF, {14{32'h0}}, 32'h1234_5678}};
    for (int i = 0; i < 5; i++) begin
      vif.full_valid_i = tbl[i].fv;
      vif.full_reg_i   = tbl[i].r;
      vif.full_mask_i  = tbl[i].m;
      vif.full_value_i = tbl[i].v;
      step();
      $display("alu vector %0d: valid=%0b reg=%0h mask=%0h", i, tbl[i].fv, tbl[i].r, tbl[i].m);
      check("alu.en",    512'(vif.write_en_o), 512'(tbl[i].exp_en));
      check("alu.reg",   512'(vif.write_reg_o), 512'(tbl[i].exp_r));
      check("alu.mask",  512'(vif.write_mask_o), 512'(tbl[i].exp_m));
      check("alu.value", vif.write_value_o, tbl[i].exp_v);
      check("alu.done",  512'(vif.gather_done_o), 512'(0));
    end
    idle_inputs();
    step();

    // ---------------- basic gather ----------------
    $display("gather reg 41 mask 0011");
    start_gather(7'h41, 16'h0011);
    check("g.busy",  512'(vif.busy_o), 512'(1));
    check("g.ready", 512'(vif.lane_ready_o), 512'(1));
    send_lane(4'd4, 32'h0000_1234);
    send_lane(4'd0, 32'h0000_BEEF);
    check("g.flush_en",    512'(vif.write_en_o), 512'(0));
    check("g.flush_ready", 512'(vif.lane_ready_o), 512'(0));
    step();
    v = '0;
    v[31:0]   = 32'h0000_BEEF;
    v[159:128] = 32'h0000_1234;
    check_write("g.write", 7'h41, 16'h0011, v, 1'b1);
    step();
    check("g.after_en",   512'(vif.write_en_o), 512'(0));
    check("g.after_done", 512'(vif.gather_done_o), 512'(0));
    check("g.after_busy", 512'(vif.busy_o), 512'(0));

    // ---------------- collision with ALU ----------------
    $display("collision gather reg 10 vs 3 ALU writes");
    start_gather(7'h10, 16'h0001);
    send_lane(4'd0, 32'hCAFE_0001);
    for (int k = 0; k < 3; k++) begin
      w = 32'h1111_1111 * (k + 1);
      vif.full_valid_i = 1'b1;
      vif.full_reg_i   = 7'h10;
      vif.full_mask_i  = 16'hFFFF;
      vif.full_value_i = {16{w}};
      step();
      check_write("c.alu", 7'h10, 16'hFFFF, {16{w}}, 1'b0);
    end
    vif.full_valid_i = 1'b0;
    step();
    check_write("c.gather", 7'h10, 16'h0001, 512'(32'hCAFE_0001), 1'b1);

    // ---------------- out-of-mask lane ----------------
    $display("lane error mask 0002 lane 7");
    start_gather(7'h22, 16'h0002);
    send_lane(4'd7, 32'h7777_7777);
    check("e.err", 512'(vif.lane_err_o), 512'(1));
    check("e.en",  512'(vif.write_en_o), 512'(0));
    step();
    check("e.err_clear", 512'(vif.lane_err_o), 512'(0));
    check("e.busy",      512'(vif.busy_o), 512'(1));
    send_lane(4'd1, 32'h0000_0101);
    step();
    check_write("e.write", 7'h22, 16'h0002, 512'(32'h0000_0101) << 32, 1'b1);

    // ---------------- empty mask ----------------
    $display("start with mask 0");
    start_gather(7'h05, 16'h0000);
    check("z.done", 512'(vif.gather_done_o), 512'(1));
    check("z.en",   512'(vif.write_en_o), 512'(0));
    check("z.busy", 512'(vif.busy_o), 512'(0));
    step();
    check("z.done_clear", 512'(vif.gather_done_o), 512'(0));

    // ---------------- start while busy ----------------
    $display("start while busy ignored");
    start_gather(7'h33, 16'h0004);
    start_gather(7'h44, 16'h0008);
    check("b.busy", 512'(vif.busy_o), 512'(1));
    send_lane(4'd2, 32'hAAAA_5555);
    check("b.err", 512'(vif.lane_err_o), 512'(0));
    step();
    check_write("b.write", 7'h33, 16'h0004, 512'(32'hAAAA_5555) << 64, 1'b1);

    // ---------------- reset mid-gather ----------------
    $display("reset in COLLECT after 3 of 8 lanes");
    start_gather(7'h55, 16'h00FF);
    send_lane(4'd0, 32'h1);
    send_lane(4'd1, 32'h2);
    send_lane(4'd2, 32'h3);
    reset = 1'b1;
    step();
    check("r.en",    512'(vif.write_en_o), 512'(0));
    check("r.reg",   512'(vif.write_reg_o), 512'(0));
    check("r.value", vif.write_value_o, 512'(0));
    check("r.busy",  512'(vif.busy_o), 512'(0));
    check("r.ready", 512'(vif.lane_ready_o), 512'(0));
    reset = 1'b0;
    step();
    check("r.post_en",   512'(vif.write_en_o), 512'(0));
    check("r.post_done", 512'(vif.gather_done_o), 512'(0));
    start_gather(7'h56, 16'h0003);
    send_lane(4'd1, 32'h0BAD_F00D);
    send_lane(4'd0, 32'h0000_0042);
    step();
    check_write("r.new", 7'h56, 16'h0003, {448'd0, 32'h0BAD_F00D, 32'h0000_0042}, 1'b1);

    // ---------------- random traffic vs reference model ----------------
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_active = 1'b0;
    m_gmask = '0;
    m_remaining = '0;
    m_greg = '0;
    m_last_reg = '0;
    m_last_mask = '0;
    m_last_value = '0;
    for (int i = 0; i < 16; i++) m_data[i] = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic         e_en, e_done, e_err;
      logic [511:0] fv;
      int           s;
      bit           found;

      // stimulus
      vif.full_valid_i = ($urandom_range(0, 3) == 0);
      vif.full_reg_i   = 7'($urandom);
      vif.full_mask_i  = 16'($urandom);
      for (int j = 0; j < 16; j++) fv[32*j +: 32] = $urandom;
      vif.full_value_i = fv;
      vif.start_i      = ($urandom_range(0, 3) == 0);
      vif.dest_reg_i   = 7'($urandom);
      case ($urandom_range(0, 4))
        0:       vif.lane_mask_i = 16'h0000;
        1:       vif.lane_mask_i = 16'hFFFF;
        default: vif.lane_mask_i = 16'($urandom & $urandom);
      endcase
      vif.lane_valid_i = ($urandom_range(0, 1) == 1);
      vif.lane_data_i  = $urandom;
      vif.lane_index_i = 4'($urandom);
      if (m_remaining != 0 && $urandom_range(0, 3) != 0) begin
        s = $urandom_range(0, 15);
        found = 1'b0;
        for (int j = 0; j < 16; j++) begin
          if (!found && m_remaining[(s + j) % 16]) begin
            vif.lane_index_i = 4'((s + j) % 16);
            found = 1'b1;
          end
        end
      end

      // reference model
      e_en = 1'b0;
      e_done = 1'b0;
      e_err = 1'b0;
      if (vif.full_valid_i) begin
        e_en = 1'b1;
        m_last_reg = vif.full_reg_i;
        m_last_mask = vif.full_mask_i;
        m_last_value = vif.full_value_i;
      end
      if (!m_active) begin
        if (vif.start_i) begin
          if (vif.lane_mask_i == 0) begin
            e_done = 1'b1;
          end else begin
            m_active = 1'b1;
            m_gmask = vif.lane_mask_i;
            m_remaining = vif.lane_mask_i;
            m_greg = vif.dest_reg_i;
            for (int j = 0; j < 16; j++) m_data[j] = '0;
          end
        end
      end else if (m_remaining != 0) begin
        if (vif.lane_valid_i) begin
          if (m_gmask[vif.lane_index_i]) begin
            m_data[vif.lane_index_i] = vif.lane_data_i;
            m_remaining[vif.lane_index_i] = 1'b0;
          end else begin
            e_err = 1'b1;
          end
        end
      end else if (!vif.full_valid_i) begin
        e_en = 1'b1;
        e_done = 1'b1;
        m_active = 1'b0;
        m_last_reg = m_greg;
        m_last_mask = m_gmask;
        for (int j = 0; j < 16; j++) m_last_value[32*j +: 32] = m_gmask[j] ? m_data[j] : 32'h0;
      end

      step();
      check("rnd.en",    512'(vif.write_en_o), 512'(e_en));
      check("rnd.reg",   512'(vif.write_reg_o), 512'(m_last_reg));
      check("rnd.mask",  512'(vif.write_mask_o), 512'(m_last_mask));
      check("rnd.value", vif.write_value_o, m_last_value);
      check("rnd.done",  512'(vif.gather_done_o), 512'(e_done));
      check("rnd.err",   512'(vif.lane_err_o), 512'(e_err));
      check("rnd.busy",  512'(vif.busy_o), 512'(m_active));
      check("rnd.ready", 512'(vif.lane_ready_o), 512'(m_active && m_remaining != 0));
    end
    $display("random phase: 3000 cycles applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
